// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit: FSM states, instruction width,
// the NOP encoding and the default reset/trap vectors.
package pc_fetch_unit_pkg;

    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP                  = 32'h0000_0013;
    localparam logic [ILEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        TRAP  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus: instruction memory handshake, redirect inputs, PC/instruction
// outputs and the misaligned-target trap handshake.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic            imem_req;
    logic [ILEN-1:0] imem_addr;
    logic            imem_ready;
    logic [ILEN-1:0] instr_in;
    logic            stall;
    logic            branch_taken;
    logic            jump;
    logic            jalr;
    logic [ILEN-1:0] branch_target;
    logic [ILEN-1:0] jalr_target;
    logic [ILEN-1:0] pc_out;
    logic [ILEN-1:0] pc_plus4;
    logic [ILEN-1:0] instr_out;
    logic            instr_valid;
    logic            trap;
    logic [ILEN-1:0] trap_pc;
    logic            trap_ack;

    modport master (
        output imem_req, imem_addr, pc_out, pc_plus4, instr_out, instr_valid, trap, trap_pc,
        input  imem_ready, instr_in, stall, branch_taken, jump, jalr,
               branch_target, jalr_target, trap_ack
    );

    modport slave (
        input  imem_req, imem_addr, pc_out, pc_plus4, instr_out, instr_valid, trap, trap_pc,
        output imem_ready, instr_in, stall, branch_taken, jump, jalr,
               branch_target, jalr_target, trap_ack
    );

endinterface

// File: rtl/pc_fetch_unit_next_pc_select.sv
// Next-PC mux (jalr > jump > branch > sequential) and misaligned redirect detection.
module next_pc_select
    import pc_fetch_unit_pkg::*;
(
    input  logic [ILEN-1:0] pc_i,
    input  logic            branch_taken_i,
    input  logic            jump_i,
    input  logic            jalr_i,
    input  logic [ILEN-1:0] branch_target_i,
    input  logic [ILEN-1:0] jalr_target_i,
    output logic [ILEN-1:0] next_pc_o,
    output logic [ILEN-1:0] pc_plus4_o,
    output logic            misaligned_o
);

    logic redirect;

    assign pc_plus4_o = pc_i + ILEN'(4);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        next_pc_o = pc_plus4_o;
        redirect  = 1'b0;
        if (jalr_i) begin
            next_pc_o = jalr_target_i & ~ILEN'(1);
            redirect  = 1'b1;
        end else if (jump_i || branch_taken_i) begin
            next_pc_o = branch_target_i;
            redirect  = 1'b1;
        end
    end

    // Only a redirect can land off a word boundary; bit 0 of jalr is already cleared.
    assign misaligned_o = redirect && next_pc_o[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: IDLE/FETCH/TRAP sequencer that retires one instruction per accepted
// fetch, applies redirects and traps on misaligned redirect targets.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [ILEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.master bus
);

    state_t          state_q, state_d;
    logic [ILEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [ILEN-1:0] trap_pc_q, trap_pc_d;
    logic            valid_q, valid_d;

    logic            retire;
    logic            misaligned;
    logic [ILEN-1:0] next_pc;
    logic [ILEN-1:0] pc_plus4;

    next_pc_select u_next_pc_select (
        .pc_i            (pc_q),
        .branch_taken_i  (bus.branch_taken),
        .jump_i          (bus.jump),
        .jalr_i          (bus.jalr),
        .branch_target_i (bus.branch_target),
        .jalr_target_i   (bus.jalr_target),
        .next_pc_o       (next_pc),
        .pc_plus4_o      (pc_plus4),
        .misaligned_o    (misaligned)
    );

    assign retire = (state_q == FETCH) && bus.imem_ready && !bus.stall;

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (retire && misaligned) state_d = TRAP;
            TRAP:    if (bus.trap_ack) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.trap     = 1'b0;
        unique case (state_q)
            FETCH:   bus.imem_req = 1'b1;
            TRAP:    bus.trap     = 1'b1;
            default: ;
        endcase
    end

    // Redirect inputs only matter on the retirement cycle.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        trap_pc_d = trap_pc_q;
        valid_d   = retire;
        if (retire) begin
            instr_d = bus.instr_in;
            if (misaligned) begin
                pc_d      = TRAP_VECTOR;
                trap_pc_d = next_pc;
            end else begin
                pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            instr_q   <= NOP;
            trap_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            trap_pc_q <= trap_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc_out      = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.trap_pc     = trap_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus a randomized run against
// a behavioural model of the fetch rules.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        bus.imem_ready    = 1'b0;
        bus.instr_in      = '0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.jump          = 1'b0;
        bus.jalr          = 1'b0;
        bus.branch_target = '0;
        bus.jalr_target   = '0;
        bus.trap_ack      = 1'b0;
    endtask

    // Leaves the DUT in its first (IDLE) cycle after reset release.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Leaves the DUT in FETCH at the reset vector.
    task automatic start();
        do_reset();
        @(posedge clk); #1;
    endtask

    task automatic goto_pc(input logic [31:0] tgt);
        bus.imem_ready    = 1'b1;
        bus.jump          = 1'b1;
        bus.branch_target = tgt;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        start();
        bus.imem_ready    = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0106;
        @(posedge clk); #1;
        clear_inputs();
        checks++; if (bus.trap !== 1'b1) begin errors++; $display("FAIL reset_pre_trap: got %b expected 1", bus.trap); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.pc_out !== RV) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc_out, RV); end
        checks++; if (bus.instr_out !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", bus.instr_out); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b expected 0", bus.trap); end
        checks++; if (bus.trap_pc !== 32'h0) begin errors++; $display("FAIL reset_trap_pc: got %h expected 0", bus.trap_pc); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", bus.imem_req); end
        @(posedge clk); #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b expected 1", bus.imem_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL idle_no_valid: got %b expected 0", bus.instr_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        do_reset();
        bus.imem_ready = 1'b1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL seq_idle_req: got %b expected 0", bus.imem_req); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_addr = 32'(4 * i);
            bus.instr_in = {16'hC0DE, exp_addr[15:0]};
            checks++; if (bus.imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, bus.imem_addr, exp_addr); end
            checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %b expected 1", i, bus.imem_req); end
            checks++; if (bus.instr_valid !== (i > 0)) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected %b", i, bus.instr_valid, i > 0); end
            if (i > 0) begin
                checks++; if (bus.instr_out !== {16'hC0DE, exp_addr[15:0] - 16'd4}) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, bus.instr_out, {16'hC0DE, exp_addr[15:0] - 16'd4}); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_redirect();
        start();
        goto_pc(32'h0000_0040);
        checks++; if (bus.pc_out !== 32'h40) begin errors++; $display("FAIL redir_setup: got %h expected 00000040", bus.pc_out); end
        bus.imem_ready = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h20;
        @(posedge clk); #1;
        clear_inputs();
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL redir_branch: got %h expected 00000020", bus.imem_addr); end
        bus.imem_ready = 1'b1; bus.jump = 1'b1; bus.jalr = 1'b1;
        bus.branch_target = 32'h0000_0400; bus.jalr_target = 32'h81;
        @(posedge clk); #1;
        clear_inputs();
        checks++; if (bus.imem_addr !== 32'h80) begin errors++; $display("FAIL redir_jalr: got %h expected 00000080", bus.imem_addr); end
        checks++; if (bus.trap !== 1'b0) begin errors++; $display("FAIL redir_jalr_trap: got %b expected 0", bus.trap); end
        bus.jalr = 1'b1; bus.jalr_target = 32'h500;
        @(posedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h80) begin errors++; $display("FAIL redir_ignored_not_ready: got %h expected 00000080", bus.imem_addr); end
        bus.imem_ready = 1'b1; bus.stall = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        checks++; if (bus.imem_addr !== 32'h80) begin errors++; $display("FAIL redir_ignored_stall: got %h expected 00000080", bus.imem_addr); end
    endtask

    task automatic test_stall();
        start();
        goto_pc(32'h0000_0010);
        bus.imem_ready = 1'b1; bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.pc_out !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 00000010", i, bus.pc_out); end
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, bus.instr_valid); end
            checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 1", i, bus.imem_req); end
        end
        bus.stall = 1'b0;
        @(posedge clk); #1;
        clear_inputs();
        checks++; if (bus.pc_out !== 32'h14) begin errors++; $display("FAIL stall_resume_pc: got %h expected 00000014", bus.pc_out); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_resume_valid: got %b expected 1", bus.instr_valid); end
    endtask

    task automatic test_trap();
        start();
        bus.imem_ready = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h102;
        bus.instr_in = 32'hDEAD_0001;
        @(posedge clk); #1;
        clear_inputs();
        bus.imem_ready = 1'b1;
        checks++; if (bus.trap !== 1'b1) begin errors++; $display("FAIL trap_raise: got %b expected 1", bus.trap); end
        checks++; if (bus.trap_pc !== 32'h102) begin errors++; $display("FAIL trap_pc: got %h expected 00000102", bus.trap_pc); end
        checks++; if (bus.pc_out !== TV) begin errors++; $display("FAIL trap_vector: got %h expected %h", bus.pc_out, TV); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL trap_fault_valid: got %b expected 1", bus.instr_valid); end
        checks++; if (bus.instr_out !== 32'hDEAD_0001) begin errors++; $display("FAIL trap_fault_instr: got %h expected dead0001", bus.instr_out); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.trap !== 1'b1) begin errors++; $display("FAIL trap_hold[%0d]: got %b expected 1", i, bus.trap); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL trap_req[%0d]: got %b expected 0", i, bus.imem_req); end
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL trap_valid[%0d]: got %b expected 0", i, bus.instr_valid); end
            checks++; if (bus.pc_out !== TV) begin errors++; $display("FAIL trap_pc_hold[%0d]: got %h expected %h", i, bus.pc_out, TV); end
        end
        bus.trap_ack = 1'b1;
        @(posedge clk); #1;
        bus.trap_ack = 1'b0;
        checks++; if (bus.trap !== 1'b0) begin errors++; $display("FAIL trap_ack_clear: got %b expected 0", bus.trap); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL trap_ack_req: got %b expected 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== TV) begin errors++; $display("FAIL trap_ack_addr: got %h expected %h", bus.imem_addr, TV); end
        @(posedge clk); #1;
        clear_inputs();
        checks++; if (bus.imem_addr !== TV + 32'd4) begin errors++; $display("FAIL trap_resume_addr: got %h expected %h", bus.imem_addr, TV + 32'd4); end
    endtask

    task automatic test_wrap_and_abort();
        start();
        goto_pc(32'hFFFF_FFFC);
        checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected 00000000", bus.pc_plus4); end
        bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 00000000", bus.pc_out); end
        checks++; if (bus.trap !== 1'b0) begin errors++; $display("FAIL wrap_no_trap: got %b expected 0", bus.trap); end
        goto_pc(32'h0000_0200);
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.pc_out !== RV) begin errors++; $display("FAIL abort_pc: got %h expected %h", bus.pc_out, RV); end
        bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL abort_no_valid[%0d]: got %b expected 0", i, bus.instr_valid); end
        end
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_instr, m_trap_pc, tgt;
        bit          m_warm, m_trapped, m_valid, retire, redirect;
        do_reset();
        m_pc = RV; m_instr = 32'h0000_0013; m_trap_pc = '0;
        m_warm = 1'b1; m_trapped = 1'b0; m_valid = 1'b0;
        for (int n = 0; n < 600; n++) begin
            bus.imem_ready    = ($urandom_range(3) != 0);
            bus.stall         = ($urandom_range(3) == 0);
            bus.branch_taken  = ($urandom_range(5) == 0);
            bus.jump          = ($urandom_range(7) == 0);
            bus.jalr          = ($urandom_range(7) == 0);
            bus.instr_in      = $urandom;
            bus.trap_ack      = ($urandom_range(2) == 0);
            bus.branch_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) bus.branch_target = bus.branch_target | 32'h2;
            bus.jalr_target   = $urandom;
            if ($urandom_range(7) != 0) bus.jalr_target = bus.jalr_target & 32'hFFFF_FFFD;

            retire  = !m_warm && !m_trapped && bus.imem_ready && !bus.stall;
            m_valid = retire;
            if (m_warm) begin
                m_warm = 1'b0;
            end else if (m_trapped) begin
                if (bus.trap_ack) m_trapped = 1'b0;
            end else if (retire) begin
                redirect = bus.jalr || bus.jump || bus.branch_taken;
                if (bus.jalr)      tgt = bus.jalr_target - (bus.jalr_target % 2);
                else if (redirect) tgt = bus.branch_target;
                else               tgt = m_pc + 32'd4;
                m_instr = bus.instr_in;
                if (redirect && (tgt % 4) >= 2) begin
                    m_trapped = 1'b1; m_trap_pc = tgt; m_pc = TV;
                end else begin
                    m_pc = tgt;
                end
            end

            @(posedge clk); #1;
            checks++; if (bus.imem_req !== (!m_warm && !m_trapped)) begin errors++; $display("FAIL rnd_req[%0d]: got %b expected %b", n, bus.imem_req, !m_warm && !m_trapped); end
            checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, bus.imem_addr, m_pc); end
            checks++; if (bus.pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4[%0d]: got %h expected %h", n, bus.pc_plus4, m_pc + 32'd4); end
            checks++; if (bus.instr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, bus.instr_valid, m_valid); end
            checks++; if (bus.instr_out !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", n, bus.instr_out, m_instr); end
            checks++; if (bus.trap !== m_trapped) begin errors++; $display("FAIL rnd_trap[%0d]: got %b expected %b", n, bus.trap, m_trapped); end
            checks++; if (bus.trap_pc !== m_trap_pc) begin errors++; $display("FAIL rnd_trap_pc[%0d]: got %h expected %h", n, bus.trap_pc, m_trap_pc); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_trap();
        test_wrap_and_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, SHALL set the PC loaded on a misaligned-target trap.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  32  fetch address; SHALL equal pc_out.
REQ-008 imem_ready  in  1  instruction memory has returned instr_in this cycle.
REQ-009 instr_in  in  32  fetched instruction word.
REQ-010 stall  in  1  downstream hazard; blocks retirement of the current fetch.
REQ-011 branch_taken, jump, jalr  in  1 each  redirect selects from decode/ALU.
REQ-012 branch_target  in  32  PC+offset from the branch adder (used for branches and JAL).
REQ-013 jalr_target  in  32  rs1+imm from the ALU.
REQ-014 pc_out, pc_plus4  out  32 each  current PC and PC+4 (pc_plus4 is the link value).
REQ-015 instr_out  out  32 / instr_valid  out  1  latched instruction and its one-cycle valid pulse.
REQ-016 trap  out  1 / trap_pc  out  32 / trap_ack  in  1  misaligned-target trap request, offending address, and acknowledge.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, FETCH and TRAP.
REQ-018 IDLE SHALL last one cycle after reset, drive imem_req=0, and go to FETCH.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc_out.
REQ-020 Retirement SHALL occur on a FETCH cycle with imem_ready=1 and stall=0: instr_out<=instr_in, instr_valid=1 next cycle only, pc<=next_pc.
REQ-021 With imem_ready=1 and stall=1, pc and instr_out SHALL hold, instr_valid SHALL be 0, and imem_req SHALL stay 1.
REQ-022 next_pc priority SHALL be: jalr ? {jalr_target[31:1],1'b0} : jump ? branch_target : branch_taken ? branch_target : pc+4.
REQ-023 Redirect inputs SHALL be sampled only on the retirement cycle; at all other times they SHALL be ignored.
REQ-024 All PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000, no flag).
REQ-025 If the selected redirect target has bit[1]!=0 at retirement: state<=TRAP, trap=1, trap_pc<=target, pc<=TRAP_VECTOR; instr_valid SHALL still pulse for the faulting instruction.
REQ-026 In TRAP, imem_req SHALL be 0 and trap SHALL stay 1 until trap_ack=1; the FSM SHALL then go to FETCH the next cycle with trap=0.
REQ-027 trap_ack SHALL be ignored outside TRAP.
REQ-028 pc_plus4 SHALL always equal pc_out+4, combinationally.

Reset
REQ-029 Reset SHALL asynchronously force state=IDLE, pc_out=RESET_VECTOR, instr_out=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, trap=0, trap_pc=0.
REQ-030 Reset asserted mid-fetch or in TRAP SHALL abort the operation; no instr_valid pulse SHALL follow.

Structure
REQ-031 A shared package SHALL hold the state enum, NOP encoding, ILEN=32, and the default vectors.
REQ-032 Next-PC selection and the alignment check SHALL live in a combinational sub-module named next_pc_select.

Verification
REQ-033 Reset release, imem_ready=1 every cycle -> addresses 0x0, 0x4, 0x8, with instr_valid pulsing each cycle from the third cycle.
REQ-034 Retire at pc=0x40 with branch_taken=1 and branch_target=0x20 -> next imem_addr=0x20; with jump=1 and jalr=1 together and jalr_target=0x81 -> next address 0x80.
REQ-035 stall=1 for 3 cycles with imem_ready=1 at pc=0x10 -> pc holds 0x10, no instr_valid, then resume to 0x14.
REQ-036 branch_taken=1 with branch_target=0x102 -> trap=1, trap_pc=0x102, pc=0x100; trap_ack after 2 cycles -> fetch from 0x100.
REQ-037 pc=0xFFFF_FFFC retire -> next pc=0x0; reset asserted while imem_ready is low -> pc=RESET_VECTOR immediately, no valid pulse.
